// File: rtl/uart_arb_pkg.sv
// Shared types for the UART TX arbiter: FSM states, requester indices, output slot.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_ISP = 2'd1,
    GNT_USR = 2'd2
  } arb_state_t;

  localparam int REQ_ISP = 0;
  localparam int REQ_USR = 1;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } tx_slot_t;

endpackage

// File: rtl/uart_arb_idle_timer.sv
// Counts granted cycles without an accepted byte; pulses expire_o when the
// owner has been silent for TIMEOUT_CYCLES cycles.
module uart_arb_idle_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at LIMIT so a missed clear can never wrap into a fresh window.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != LIMIT))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = en_i && !clear_i && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular arbiter sharing one UART TX serializer between the ISP
// debugger and the user UART. Define UART_ARB_ISP_PRIO_EN for strict ISP priority.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] EOL_BYTE       = 8'h0A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       isp_valid,
  input  logic [7:0] isp_byte,
  output logic       isp_ready,
  input  logic       usr_valid,
  input  logic [7:0] usr_byte,
  output logic       usr_ready,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  input  logic       tx_ready,
  output logic [1:0] grant
);

  arb_state_t state_q, state_d;
  tx_slot_t   slot_q, slot_d;
  logic       granted, slot_free, own_valid, accept, expire, release_gnt, isp_wins;
  logic [7:0] own_byte;

  assign granted   = (state_q != IDLE);
  assign slot_free = !slot_q.valid || tx_ready;
  assign isp_ready = (state_q == GNT_ISP) && slot_free;
  assign usr_ready = (state_q == GNT_USR) && slot_free;

  assign own_valid   = (state_q == GNT_USR) ? usr_valid : isp_valid;
  assign own_byte    = (state_q == GNT_USR) ? usr_byte  : isp_byte;
  assign accept      = granted && own_valid && slot_free;
  assign release_gnt = (accept && (own_byte == EOL_BYTE)) || expire;

  always_comb begin
    grant          = '0;
    grant[REQ_ISP] = (state_q == GNT_ISP);
    grant[REQ_USR] = (state_q == GNT_USR);
  end

`ifdef UART_ARB_ISP_PRIO_EN
  assign isp_wins = isp_valid;
`else
  logic last_usr_q, last_usr_d;

  // Reset value favours ISP on the first tie.
  assign isp_wins = isp_valid && (!usr_valid || last_usr_q);

  always_comb begin
    last_usr_d = last_usr_q;
    if (granted && release_gnt)
      last_usr_d = (state_q == GNT_USR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_usr_q <= 1'b1;
    else     last_usr_q <= last_usr_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (isp_wins)       state_d = GNT_ISP;
        else if (usr_valid) state_d = GNT_USR;
      end
      GNT_ISP, GNT_USR: if (release_gnt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The slot drains on its own handshake, regardless of who holds the grant.
  always_comb begin
    slot_d = slot_q;
    if (accept) begin
      slot_d.valid = 1'b1;
      slot_d.data  = own_byte;
    end else if (tx_ready) begin
      slot_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  uart_arb_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (accept || !granted),
    .en_i    (granted && !accept),
    .expire_o(expire)
  );

  assign tx_valid = slot_q.valid;
  assign tx_byte  = slot_q.data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter against a message-level reference model.
module tb_uart_tx_arbiter;

  localparam int TO = 16;
  localparam logic [7:0] EOL = 8'h0A;
`ifdef UART_ARB_ISP_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       isp_valid, usr_valid, tx_ready;
  logic [7:0] isp_byte, usr_byte;
  logic       isp_ready, usr_ready, tx_valid;
  logic [7:0] tx_byte;
  logic [1:0] grant;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(TO), .EOL_BYTE(EOL)) dut (
    .clk(clk), .rst(rst),
    .isp_valid(isp_valid), .isp_byte(isp_byte), .isp_ready(isp_ready),
    .usr_valid(usr_valid), .usr_byte(usr_byte), .usr_ready(usr_ready),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] isp_q[$], usr_q[$], out_log[$];
  logic [1:0] gseq[$];
  int isp_pct = 100, usr_pct = 100, rdy_pct = 100;
  int pushed;

  // Reference model: owner 0=none 1=isp 2=usr; silence counted in whole cycles.
  int         m_own, m_last, m_sil, m_acc_own;
  logic       m_tv;
  logic [7:0] m_tb;

  logic [7:0] exp_tie [6] = '{8'h4F, 8'h4B, 8'h0A, 8'h68, 8'h69, 8'h0A};
  logic [7:0] exp_bp  [5] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0A};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_last = 2; m_sil = 0; m_acc_own = 0; m_tv = 1'b0; m_tb = 8'h00;
  endtask

  task automatic drive();
    isp_valid = (isp_q.size() > 0) && (int'($urandom_range(99)) < isp_pct);
    usr_valid = (usr_q.size() > 0) && (int'($urandom_range(99)) < usr_pct);
    isp_byte  = (isp_q.size() > 0) ? isp_q[0] : 8'($urandom);
    usr_byte  = (usr_q.size() > 0) ? usr_q[0] : 8'($urandom);
    tx_ready  = (int'($urandom_range(99)) < rdy_pct);
  endtask

  // One clock: drive, check every output at negedge, advance the model.
  task automatic cyc();
    logic free;
    int acc;
    logic [7:0] ab;
    drive();
    @(negedge clk);
    free = !m_tv || tx_ready;
    chk("grant", grant, (m_own == 1) ? 1 : (m_own == 2) ? 2 : 0);
    chk("isp_ready", isp_ready, (m_own == 1) && free);
    chk("usr_ready", usr_ready, (m_own == 2) && free);
    chk("tx_valid", tx_valid, m_tv);
    chk("tx_byte", tx_byte, m_tb);
    if (tx_valid && tx_ready) out_log.push_back(tx_byte);
    acc = 0; ab = 8'h00;
    if (m_own == 1 && isp_valid && free) begin
      acc = 1; ab = isp_byte; void'(isp_q.pop_front());
    end else if (m_own == 2 && usr_valid && free) begin
      acc = 2; ab = usr_byte; void'(usr_q.pop_front());
    end
    if (acc != 0) begin m_tv = 1'b1; m_tb = ab; end
    else if (tx_ready) m_tv = 1'b0;
    m_acc_own = acc;
    if (m_own == 0) begin
      if (isp_valid && usr_valid) m_own = (PRIO || m_last == 2) ? 1 : 2;
      else if (isp_valid)         m_own = 1;
      else if (usr_valid)         m_own = 2;
      m_sil = 0;
    end else if (acc != 0) begin
      m_sil = 0;
      if (ab == EOL) begin m_last = m_own; m_own = 0; end
    end else begin
      m_sil++;
      if (m_sil == TO) begin m_last = m_own; m_own = 0; m_sil = 0; end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_until_idle(input string tag, input int bound);
    int n = 0;
    while ((isp_q.size() > 0 || usr_q.size() > 0 || m_own != 0 || m_tv) && n < bound) begin
      cyc();
      if (grant != 2'b00 && (gseq.size() == 0 || gseq[$] != grant)) gseq.push_back(grant);
      n++;
    end
    chk({tag, "_drained"}, n < bound, 1);
  endtask

  function automatic logic [1:0] gat(input int i);
    return (gseq.size() > i) ? gseq[i] : 2'b11;
  endfunction

  task automatic push_msg(input int who);
    int len = $urandom_range(1, 4);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(8'h20, 8'h7E));
      if (i == len - 1 && $urandom_range(4) != 0) b = EOL;
      if (who == 1) isp_q.push_back(b); else usr_q.push_back(b);
    end
    pushed += len;
  endtask

  initial begin
    int cnt;
    logic [7:0] hold;
    isp_valid = 1'b0; usr_valid = 1'b0; tx_ready = 1'b0;
    isp_byte = 8'h00; usr_byte = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_isp_ready", isp_ready, 0);
    chk("rst_usr_ready", usr_ready, 0);
    rst = 1'b0;
    repeat (3) cyc();
    chk("idle_no_req", grant, 0);

    // Tie right after reset: ISP message first, then USR.
    out_log.delete(); gseq.delete();
    isp_q = {8'h4F, 8'h4B, 8'h0A};
    usr_q = {8'h68, 8'h69, 8'h0A};
    run_until_idle("tie", 60);
    chk("tie_len", out_log.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("tie_byte%0d", i), (out_log.size() > i) ? out_log[i] : 8'hxx, exp_tie[i]);
    chk("tie_gnt0", gat(0), 2'b01);
    chk("tie_gnt1", gat(1), 2'b10);

    // Last owner USR: ISP wins in either build.
    gseq.delete();
    isp_q = {8'h52, 8'h0A};
    usr_q = {8'h55, 8'h0A};
    run_until_idle("rr1", 60);
    chk("rr1_gnt0", gat(0), 2'b01);
    chk("rr1_gnt1", gat(1), 2'b10);

    // Last owner ISP: round-robin hands the tie to USR unless ISP has priority.
    isp_q = {8'h53, 8'h0A};
    run_until_idle("isp_only", 60);
    gseq.delete();
    isp_q = {8'h54, 8'h0A};
    usr_q = {8'h56, 8'h0A};
    run_until_idle("rr2", 60);
    chk("rr2_gnt0", gat(0), PRIO ? 2'b01 : 2'b10);

    // Backpressure for 5 cycles mid-message.
    out_log.delete();
    isp_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h0A};
    repeat (3) cyc();
    rdy_pct = 0;
    hold = tx_byte;
    repeat (5) begin
      cyc();
      chk("bp_stable", tx_byte, hold);
      chk("bp_isp_ready", isp_ready, 0);
    end
    rdy_pct = 100;
    run_until_idle("bp", 60);
    chk("bp_len", out_log.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("bp_byte%0d", i), (out_log.size() > i) ? out_log[i] : 8'hxx, exp_bp[i]);

    // Timeout: USR sends one byte with no EOL and goes quiet while ISP waits.
    usr_q = {8'h61};
    cnt = 0;
    while (m_acc_own != 2 && cnt < 10) begin cyc(); cnt++; end
    chk("to_accept_seen", cnt < 10, 1);
    isp_q = {8'h41, 8'h0A};
    cnt = 0;
    while (grant == 2'b10 && cnt < 100) begin cnt++; cyc(); end
    chk("to_len", cnt, TO);
    chk("to_idle", grant, 2'b00);
    cyc();
    chk("to_isp_gnt", grant, 2'b01);
    run_until_idle("to", 60);

    // Randomized traffic, valid gaps, backpressure, occasional missing EOL.
    out_log.delete();
    pushed = 0;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) begin
        isp_pct = $urandom_range(20, 100);
        usr_pct = $urandom_range(20, 100);
        rdy_pct = $urandom_range(30, 100);
      end
      if (isp_q.size() == 0 && $urandom_range(3) == 0) push_msg(1);
      if (usr_q.size() == 0 && $urandom_range(3) == 0) push_msg(2);
      cyc();
    end
    isp_pct = 100; usr_pct = 100; rdy_pct = 100;
    run_until_idle("rand", 400);
    chk("rand_count", out_log.size(), pushed);

    // Async reset while ISP holds the grant and a byte is stalled.
    isp_q = {8'h71, 8'h72, 8'h73, 8'h0A};
    cyc(); cyc();
    rdy_pct = 0;
    cyc();
    chk("pre_rst_tx_valid", tx_valid, 1);
    chk("pre_rst_grant", grant, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("async_tx_valid", tx_valid, 0);
    chk("async_grant", grant, 2'b00);
    chk("async_isp_ready", isp_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    isp_q.delete(); usr_q.delete();
    isp_valid = 1'b0; usr_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    rdy_pct = 100;
    gseq.delete();
    isp_q = {8'h75, 8'h0A};
    usr_q = {8'h76, 8'h0A};
    run_until_idle("post_rst", 60);
    chk("post_rst_gnt0", gat(0), 2'b01);
    chk("post_rst_gnt1", gat(1), 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
